// File: rtl/agc_bank_translator.sv
// AGC bank translator: holds EB/FB/SB and maps 12-bit CPU addresses to flat
// physical addresses through a one-stage registered valid/ready pipeline.
module agc_bank_translator #(
  parameter int EBANK_W      = 3,
  parameter int FBANK_W      = 5,
  parameter int OUT_W        = 16,
  parameter int NUM_FBANKS   = 36,
  parameter bit SUPERBANK_EN = 1'b1,
  parameter int FCNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bank_we,
  input  logic [1:0]                 bank_sel,
  input  logic [FBANK_W+EBANK_W-1:0] bank_wdata,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [11:0]                req_addr,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [OUT_W-1:0]           resp_addr,
  output logic [1:0]                 resp_region,
  output logic                       resp_fault,
  output logic [EBANK_W-1:0]         eb_q,
  output logic [FBANK_W-1:0]         fb_q,
  output logic                       sb_q,
  output logic [FCNT_W-1:0]          fault_count
);

  typedef enum logic [1:0] {
    REG_UNSW_ERASABLE = 2'b00,
    REG_SW_ERASABLE   = 2'b01,
    REG_SW_FIXED      = 2'b10,
    REG_FIXED_FIXED   = 2'b11
  } region_e;

  logic               accept;
  logic               pop;
  logic               sbEff;
  logic [FBANK_W:0]   fixedBank;
  logic [OUT_W-1:0]   nextAddr;
  region_e            nextRegion;
  logic               nextFault;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign pop       = resp_valid && resp_ready;
  assign sbEff     = SUPERBANK_EN && sb_q;

  // NOTE: every output of always_comb is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    nextAddr   = '0;
    nextRegion = REG_UNSW_ERASABLE;
    nextFault  = 1'b0;
    fixedBank  = {1'b0, fb_q};
    // Superbank lifts the top quarter of FB (banks 30-37 style) by eight.
    if (sbEff && (&fb_q[FBANK_W-1 -: 2]))
      fixedBank = {1'b0, fb_q} + (FBANK_W+1)'(8);

    if (req_addr[11]) begin
      nextAddr   = OUT_W'(req_addr);
      nextRegion = REG_FIXED_FIXED;
    end else if (req_addr[10]) begin
      nextRegion = REG_SW_FIXED;
      if (int'(fixedBank) >= NUM_FBANKS)
        nextFault = 1'b1;
      else
        nextAddr = OUT_W'({fixedBank, req_addr[9:0]});
    end else if (req_addr[9:8] == 2'b11) begin
      nextAddr   = OUT_W'({eb_q, req_addr[7:0]});
      nextRegion = REG_SW_ERASABLE;
    end else begin
      nextAddr = OUT_W'(req_addr);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what lets a same-cycle bank write leave
  // the accepted request translating with the old bank registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eb_q <= '0;
      fb_q <= '0;
      sb_q <= 1'b0;
    end else if (bank_we) begin
      unique case (bank_sel)
        2'b00: eb_q <= bank_wdata[EBANK_W-1:0];
        2'b01: fb_q <= bank_wdata[FBANK_W-1:0];
        2'b10: begin
          eb_q <= bank_wdata[EBANK_W-1:0];
          fb_q <= bank_wdata[FBANK_W+EBANK_W-1:EBANK_W];
        end
        2'b11: sb_q <= SUPERBANK_EN && bank_wdata[0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid  <= 1'b0;
      resp_addr   <= '0;
      resp_region <= 2'b00;
      resp_fault  <= 1'b0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      resp_addr   <= nextAddr;
      resp_region <= nextRegion;
      resp_fault  <= nextFault;
    end else if (pop) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault_count <= '0;
    else if (pop && resp_fault && (fault_count != '1))
      fault_count <= fault_count + FCNT_W'(1);
  end

endmodule

// File: tb/tb_agc_bank_translator.sv
// Scoreboard bench for agc_bank_translator: expected responses are queued at
// request acceptance and compared when the DUT hands each response over.
module tb_agc_bank_translator;

  typedef struct packed {
    logic [15:0] addr;
    logic [1:0]  region;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bank_we = 1'b0;
  logic [1:0]  bank_sel = 2'b00;
  logic [7:0]  bank_wdata = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_addr;
  logic [1:0]  resp_region;
  logic        resp_fault;
  logic [2:0]  eb_q;
  logic [4:0]  fb_q;
  logic        sb_q;
  logic [7:0]  fault_count;

  exp_t sbq[$];
  int   popCyc[$];
  int   nCompared = 0;
  int   nMismatch = 0;
  int   cyc = 0;
  logic randReady = 1'b0;
  logic [2:0] ebM = '0;
  logic [4:0] fbM = '0;
  logic       sbM = 1'b0;

  agc_bank_translator dut (
    .clk(clk), .reset(reset), .bank_we(bank_we), .bank_sel(bank_sel),
    .bank_wdata(bank_wdata), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_addr(resp_addr), .resp_region(resp_region), .resp_fault(resp_fault),
    .eb_q(eb_q), .fb_q(fb_q), .sb_q(sb_q), .fault_count(fault_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (randReady) begin
    #1 resp_ready = 1'($urandom_range(0, 1));
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] a, input logic [1:0] r, input logic f);
    exp_t e;
    e.addr = a; e.region = r; e.fault = f;
    return e;
  endfunction

  // Reference translation from the bench's own copy of the bank registers.
  function automatic exp_t model(input logic [11:0] a);
    logic [5:0] bank;
    bank = (sbM && fbM[4:3] == 2'b11) ? {1'b0, fbM} + 6'd8 : {1'b0, fbM};
    if (a[11])                return mk({4'b0, a}, 2'b11, 1'b0);
    if (a[10] && bank >= 6'd36) return mk(16'h0, 2'b10, 1'b1);
    if (a[10])                return mk({bank, a[9:0]}, 2'b10, 1'b0);
    if (a[9:8] == 2'b11)      return mk({5'b0, ebM, a[7:0]}, 2'b01, 1'b0);
    return mk({4'b0, a}, 2'b00, 1'b0);
  endfunction

  always @(negedge clk) if (!reset && resp_valid && resp_ready) begin
    checkVal("resp_expected", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      checkVal("resp_addr", 32'(resp_addr), 32'(e.addr));
      checkVal("resp_region", 32'(resp_region), 32'(e.region));
      checkVal("resp_fault", 32'(resp_fault), 32'(e.fault));
      popCyc.push_back(cyc);
    end
  end

  task automatic bankWrite(input logic [1:0] sel, input logic [7:0] d);
    bank_we = 1'b1; bank_sel = sel; bank_wdata = d;
    @(posedge clk); #1;
    bank_we = 1'b0;
    case (sel)
      2'b00: ebM = d[2:0];
      2'b01: fbM = d[4:0];
      2'b10: begin ebM = d[2:0]; fbM = d[7:3]; end
      default: sbM = d[0];
    endcase
  endtask

  // Leaves req_valid high so consecutive calls stream one request per cycle.
  task automatic issue(input logic [11:0] a, input exp_t e);
    req_valid = 1'b1; req_addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sbq.push_back(e);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checkVal("req_accept_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkVal("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #1;
    checkVal("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkVal("rst_resp_addr", 32'(resp_addr), 32'd0);
    checkVal("rst_banks", 32'({eb_q, fb_q, sb_q}), 32'd0);
    checkVal("rst_fault_count", 32'(fault_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Erasable regions
    bankWrite(2'b00, 8'b101);
    checkVal("eb_write", 32'(eb_q), 32'b101);
    issue(12'b0010_1100_1100, mk(16'b0000001011001100, 2'b00, 1'b0));
    issue(12'b0011_0011_0011, mk(16'b0000010100110011, 2'b01, 1'b0));
    idle(); drain();

    // Fixed regions
    issue(12'b1111_1000_1110, mk(16'b0000111110001110, 2'b11, 1'b0));
    idle();
    bankWrite(2'b01, 8'b10101);
    issue(12'b0111_1110_0000, mk(16'b0101011111100000, 2'b10, 1'b0));
    idle(); drain();

    // Superbank
    bankWrite(2'b01, 8'b11100);
    issue(12'b0111_1111_1111, mk(16'b0111001111111111, 2'b10, 1'b0));
    idle();
    bankWrite(2'b11, 8'b1);
    bankWrite(2'b01, 8'b11001);
    checkVal("sb_write", 32'(sb_q), 32'd1);
    issue(12'b0100_0000_0000, mk(16'b1000010000000000, 2'b10, 1'b0));
    idle(); drain();
    checkVal("fault_count_pre", 32'(fault_count), 32'd0);

    // Fault and saturating counter
    bankWrite(2'b01, 8'b11111);
    issue(12'h400, mk(16'h0, 2'b10, 1'b1));
    idle(); drain();
    checkVal("fault_count_one", 32'(fault_count), 32'd1);
    for (int i = 0; i < 254; i++) issue(12'h5A5, mk(16'h0, 2'b10, 1'b1));
    idle(); drain();
    checkVal("fault_count_max", 32'(fault_count), 32'd255);
    issue(12'h400, mk(16'h0, 2'b10, 1'b1));
    idle(); drain();
    checkVal("fault_count_sat", 32'(fault_count), 32'd255);

    // Back-pressure holds the response stable
    resp_ready = 1'b0;
    issue(12'h123, mk(16'h0123, 2'b00, 1'b0));
    req_addr = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("bp_req_ready", 32'(req_ready), 32'd0);
      checkVal("bp_resp_valid", 32'(resp_valid), 32'd1);
      checkVal("bp_resp_addr", 32'(resp_addr), 32'h0123);
      @(posedge clk); #1;
    end
    idle();
    resp_ready = 1'b1;
    drain();

    // Four-request stream
    bankWrite(2'b10, {5'b00100, 3'b010});
    popCyc.delete();
    issue(12'h123, model(12'h123));
    issue(12'h345, model(12'h345));
    issue(12'hA00, model(12'hA00));
    issue(12'h5AA, model(12'h5AA));
    idle(); drain();
    checkVal("stream_count", 32'(popCyc.size()), 32'd4);
    if (popCyc.size() == 4)
      for (int i = 1; i < 4; i++) checkVal("stream_gap", 32'(popCyc[i] - popCyc[i-1]), 32'd1);

    // Bank write in the acceptance cycle
    bank_we = 1'b1; bank_sel = 2'b10; bank_wdata = {5'b01001, 3'b011};
    issue(12'b0110_1010_1010, mk(16'b0001001010101010, 2'b10, 1'b0));
    bank_we = 1'b0; ebM = 3'b011; fbM = 5'b01001;
    idle();
    checkVal("bb_fb", 32'(fb_q), 32'b01001);
    checkVal("bb_eb", 32'(eb_q), 32'b011);
    drain();

    // Randomised traffic with random consumer stalls
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        bankWrite(2'($urandom_range(0, 3)), 8'($urandom));
      end
      begin
        logic [11:0] a;
        a = 12'($urandom);
        issue(a, model(a));
      end
    end
    idle();
    randReady = 1'b0;
    @(posedge clk); #2;
    resp_ready = 1'b1;
    drain();

    // Reset discards an outstanding response
    resp_ready = 1'b0;
    issue(12'h7FF, model(12'h7FF));
    idle();
    #2 reset = 1'b1;
    #1;
    checkVal("rst2_resp_valid", 32'(resp_valid), 32'd0);
    checkVal("rst2_resp", 32'({resp_addr, resp_region, resp_fault}), 32'd0);
    checkVal("rst2_banks", 32'({eb_q, fb_q, sb_q}), 32'd0);
    checkVal("rst2_fault_count", 32'(fault_count), 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checkVal("post_rst_valid", 32'(resp_valid), 32'd0);
    checkVal("post_rst_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/agc_bank_translator.md
Name: agc_bank_translator

Overview:
- Successor to the combinational bank/address mapper for the AGC memory path.
- Holds the bank registers internally: EB (erasable bank), FB (fixed bank) and superbank bit SB.
- Translates 12-bit CPU addresses to flat physical addresses through a one-stage registered valid/ready pipeline.
- Adds parametrised widths and bank count, an out-of-range fault, region tagging and a saturating fault counter; sits between the CPU address stage and the memory array.

Parameters:
- EBANK_W, 3, width of EB.
- FBANK_W, 5, width of FB.
- OUT_W, 16, physical address width; must be >= FBANK_W+11.
- NUM_FBANKS, 36, installed switched-fixed banks; effective bank >= NUM_FBANKS faults.
- SUPERBANK_EN, 1, 0 forces SB to be treated as 0.
- FCNT_W, 8, fault counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- bank_we  in  1  bank register write strobe
- bank_sel  in  2  00=EB, 01=FB, 10=BB (FB and EB together), 11=SB
- bank_wdata  in  FBANK_W+EBANK_W  right-justified write data
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  12  CPU address
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer ready
- resp_addr  out  OUT_W  physical address
- resp_region  out  2  00 unswitched erasable, 01 switched erasable, 10 switched fixed, 11 fixed-fixed
- resp_fault  out  1  bank out of range
- eb_q  out  EBANK_W  current EB
- fb_q  out  FBANK_W  current FB
- sb_q  out  1  current SB
- fault_count  out  FCNT_W  saturating count of faulted responses

Behaviour:
Clocking and reset:
- Async reset clears EB, FB, SB, resp_valid, resp_addr, resp_region, resp_fault and fault_count to 0.
- A reset during an outstanding response discards that response; no handshake completes in the reset cycle.

Bank register writes (registered, take effect the next cycle):
- sel 00: EB = wdata[EBANK_W-1:0].
- sel 01: FB = wdata[FBANK_W-1:0].
- sel 10: EB = wdata[EBANK_W-1:0] and FB = wdata[FBANK_W+EBANK_W-1:EBANK_W].
- sel 11: SB = wdata[0]; held at 0 when SUPERBANK_EN=0.
- A request accepted in the same cycle as a bank write translates with the old bank values.

Translation (a = req_addr, computed at acceptance and registered):
- a[11]=1: fixed-fixed; addr = zero-extend(a); region 11.
- a[11:10]=01: switched fixed; region 10.
  - Effective bank fe = FB + 8 (FBANK_W+1 bits) if SB && FB[4:3]==11, otherwise fe = FB.
  - addr = zero-extend({fe, a[9:0]}).
  - fe >= NUM_FBANKS: resp_fault=1 and addr = 0.
- a[11:8]=0011: switched erasable; addr = zero-extend({EB, a[7:0]}); region 01.
- Other a[11:10]=00: unswitched erasable; addr = zero-extend(a); region 00.
- Faults occur only in region 10.

Handshake:
- Latency 1: a request accepted at edge N appears at resp_* after edge N.
- req_ready = !resp_valid || resp_ready, combinational; back-to-back throughput is 1 per cycle.
- resp_* are held stable while resp_valid && !resp_ready.
- A simultaneous response pop and request accept loads the new response.
- No accept and a pop: resp_valid goes to 0.

Fault counter:
- Increments by 1 when a faulted response is accepted (resp_valid && resp_ready && resp_fault).
- Saturates at all-ones.

Test Plan:
- Erasable, EB written 101 via sel 00: a=001011001100 -> 0000001011001100 region 00; a=001100110011 -> 0000010100110011 region 01.
- Fixed: a=111110001110 -> 0000111110001110 region 11; FB=10101, a=011111100000 -> 0101011111100000 region 10.
- Superbank: SB=0, FB=11100, a=011111111111 -> 0111001111111111; SB=1, FB=11001, a=010000000000 -> 1000010000000000.
- Fault and counter: SB=1, FB=11111 (fe=39 >= 36) -> resp_fault=1, addr 0, fault_count 0->1. Force fault_count to 255; another fault keeps it at 255.
- Back-pressure: hold resp_ready=0 for 3 cycles -> req_ready=0 and resp_* stable. Then stream 4 requests with resp_ready=1 -> 4 responses in 4 consecutive cycles, in order.
- Same-cycle write plus request: BB write changing FB 00100->01001 while accepting a=011010101010 -> response 0001001010101010 (old FB). Assert reset while resp_valid=1 -> all outputs 0 immediately.
